// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the 48 kHz audio sample path.
package audio_pkg;
    typedef logic signed [15:0] sample_t;

    localparam int FS_HZ  = 48000;
    localparam int CLK_HZ = 48000000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_t;
endpackage

// File: rtl/i2s_bitclk.sv
// i2s_bitclk: BCLK / LRCLK timebase for the I2S transmitter.
// Counts clocks per BCLK, BCLKs per slot and the L/R channel; emits the
// registered bit and word clocks plus strobes for the data path.
module i2s_bitclk #(
    parameter  int BCLK_DIV  = 20,
    parameter  int SLOT_BITS = 25,
    localparam int CW        = $clog2(BCLK_DIV),
    localparam int BW        = $clog2(SLOT_BITS)
) (
    input  logic          i_clk48,
    input  logic          i_rst48,
    input  logic          i_en,
    output logic          o_bclk,
    output logic          o_lrclk,
    output logic          o_fall,
    output logic          o_frame_start,
    output logic [BW-1:0] o_bit_cnt
);
    localparam logic [CW-1:0] BCLK_LAST = CW'(BCLK_DIV - 1);
    localparam logic [CW-1:0] BCLK_HALF = CW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);

    logic [CW-1:0] bclk_cnt_q;
    logic [BW-1:0] bit_cnt_q;
    logic          ch_q;
    logic          bclk_q;
    logic          lrclk_q;

    // Counters sit at zero outside RUN so the first RUN cycle is a frame start.
    always_ff @(posedge i_clk48) begin
        if (i_rst48 || !i_en) begin
            bclk_cnt_q <= '0;
            bit_cnt_q  <= '0;
            ch_q       <= 1'b0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
        end else begin
            if (bclk_cnt_q == BCLK_LAST) begin
                bclk_cnt_q <= '0;
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_q <= '0;
                    ch_q      <= ~ch_q;
                end else begin
                    bit_cnt_q <= bit_cnt_q + BW'(1);
                end
            end else begin
                bclk_cnt_q <= bclk_cnt_q + CW'(1);
            end
            bclk_q <= (bclk_cnt_q >= BCLK_HALF);
            // Word select moves together with the BCLK falling edge.
            if (bclk_cnt_q == '0) lrclk_q <= ch_q;
        end
    end

    assign o_bclk        = bclk_q;
    assign o_lrclk       = lrclk_q;
    assign o_fall        = i_en && (bclk_cnt_q == '0);
    assign o_frame_start = o_fall && (bit_cnt_q == '0) && !ch_q;
    assign o_bit_cnt     = bit_cnt_q;
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: latches strobed mono samples and serialises them as stereo I2S
// (same word on L and R) in the 48 MHz domain.
// Optional macro I2S_TX_LEFT_JUSTIFIED_EN selects left-justified framing
// (MSB aligned with the LRCLK edge); default is standard I2S (one-BCLK delay).
module i2s_tx
    import audio_pkg::*;
#(
    parameter int BCLK_DIV  = 20,
    parameter int SLOT_BITS = 25,
    parameter int SAMPLE_W  = 16
) (
    input  logic                i_clk48,
    input  logic                i_rst48,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic                i_valid,
    input  logic                i_mute,
    output logic                o_bclk,
    output logic                o_lrclk,
    output logic                o_sdata,
    output logic                o_active,
    output logic                o_underrun,
    output logic                o_overrun
);
    localparam int BW  = $clog2(SLOT_BITS);
    localparam int PAD = SLOT_BITS - 1 - SAMPLE_W;

    i2s_state_t           state_q;
    logic [SAMPLE_W-1:0]  hold_q;
    logic [SAMPLE_W-1:0]  word_q;
    logic [SAMPLE_W-1:0]  word_d;
    logic [SAMPLE_W-1:0]  cur_word;
    logic                 pending_q;
    logic                 sdata_q;
    logic                 underrun_q;
    logic                 overrun_q;
    logic                 fall;
    logic                 frame_start;
    logic [BW-1:0]        bit_cnt;
    logic [SLOT_BITS-1:0] slot_vec;
    logic [SLOT_BITS-1:0] slot_shift;

    i2s_bitclk #(
        .BCLK_DIV  (BCLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_bitclk (
        .i_clk48       (i_clk48),
        .i_rst48       (i_rst48),
        .i_en          (state_q == RUN),
        .o_bclk        (o_bclk),
        .o_lrclk       (o_lrclk),
        .o_fall        (fall),
        .o_frame_start (frame_start),
        .o_bit_cnt     (bit_cnt)
    );

    // Word for the coming frame: mute wins, a coincident strobe bypasses hold,
    // and with nothing pending the previous word repeats.
    always_comb begin
        word_d = word_q;
        if (i_mute)         word_d = '0;
        else if (i_valid)   word_d = i_sample;
        else if (pending_q) word_d = hold_q;
    end

    // Bit 0 of the left slot is launched in the load cycle, so use the new word there.
    assign cur_word = frame_start ? word_d : word_q;

    // Slot image MSB-first: bit slot b is slot_vec[SLOT_BITS-1-b].
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    assign slot_vec = SLOT_BITS'(cur_word) << (PAD + 1);
`else
    assign slot_vec = SLOT_BITS'(cur_word) << PAD;
`endif
    assign slot_shift = slot_vec << bit_cnt;

    // IDLE/RUN FSM, sample capture, frame-start load, status pulses and serial data.
    always_ff @(posedge i_clk48) begin
        if (i_rst48) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            word_q     <= '0;
            pending_q  <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            if (state_q == IDLE && i_valid) state_q <= RUN;
            if (i_valid) hold_q <= i_sample;
            if (frame_start) begin
                word_q     <= word_d;
                pending_q  <= i_valid;
                underrun_q <= !pending_q && !i_valid;
            end else if (i_valid) begin
                pending_q <= 1'b1;
                overrun_q <= pending_q;
            end
            if (fall) sdata_q <= slot_shift[SLOT_BITS-1];
        end
    end

    assign o_sdata    = sdata_q;
    assign o_active   = (state_q == RUN);
    assign o_underrun = underrun_q;
    assign o_overrun  = overrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed frame table plus randomized traffic against a
// cycle-position reference model of the I2S transmitter.
module tb_i2s_tx;
    import audio_pkg::*;

    localparam int D        = 20;
    localparam int S        = 25;
    localparam int SW       = 16;
    localparam int SLOT_CYC = S * D;
    localparam int FRAME    = 2 * S * D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic          mute = 1'b0;
    logic [SW-1:0] sample = '0;
    logic          bclk, lrclk, sdata, active, under, over;

    i2s_tx dut (
        .i_clk48    (clk),
        .i_rst48    (rst),
        .i_sample   (sample),
        .i_valid    (valid),
        .i_mute     (mute),
        .o_bclk     (bclk),
        .o_lrclk    (lrclk),
        .o_sdata    (sdata),
        .o_active   (active),
        .o_underrun (under),
        .o_overrun  (over)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct { int off; logic [15:0] smp; } stim_t;
    typedef struct { int f;   logic [15:0] w;   } frm_t;

    // Serial bit expected in bit slot b for word w.
    function automatic logic bit_of(input logic [15:0] w, input int b);
        logic [15:0] t;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        if (b < 0 || b >= SW) return 1'b0;
        t = w >> (SW - 1 - b);
`else
        if (b < 1 || b > SW) return 1'b0;
        t = w >> (SW - b);
`endif
        return t[0];
    endfunction

    // Whole slot image, slot bit 0 in the MSB.
    function automatic logic [S-1:0] exp_slot(input logic [15:0] w);
        logic [S-1:0] v = '0;
        for (int b = 0; b < S; b++) v = {v[S-2:0], bit_of(w, b)};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, req);
        end
    endtask

    // ---------------- reference model ----------------
    bit          mdl_en = 0;
    bit          m_run  = 0;
    bit          m_pend = 0;
    logic [15:0] m_hold = '0;
    logic [15:0] m_word = '0;
    int          m_start = 0;
    int          mj, mj0, mb, mf;
    logic [15:0] fw [0:63];
    logic        e_act = 0, e_bclk = 0, e_lr = 0, e_sd = 0, e_un = 0, e_ov = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mdl_en = 1; m_run = 0; m_pend = 0; m_hold = '0; m_word = '0;
            {e_act, e_bclk, e_lr, e_sd, e_un, e_ov} = '0;
        end else if (mdl_en) begin
            e_un = 0; e_ov = 0;
            if (!m_run) begin
                if (valid) begin
                    m_run = 1; m_start = cyc + 1; m_hold = sample; m_pend = 1;
                end
                e_act = m_run; e_bclk = 0; e_lr = 0; e_sd = 0;
            end else begin
                mj = cyc - m_start;
                if (mj % FRAME == 0) begin
                    if (mute)        m_word = '0;
                    else if (valid)  m_word = sample;
                    else if (m_pend) m_word = m_hold;
                    e_un   = !m_pend && !valid;
                    m_pend = valid;
                    fw[6'(mj / FRAME)] = m_word;
                end else begin
                    e_ov = valid && m_pend;
                    if (valid) m_pend = 1;
                end
                if (valid) m_hold = sample;
                mj0   = mj - (mj % D);
                mb    = (mj0 % SLOT_CYC) / D;
                mf    = mj0 / FRAME;
                e_act = 1;
                e_bclk = (mj % D) >= D / 2;
                e_lr  = ((mj0 / SLOT_CYC) % 2) == 1;
                e_sd  = bit_of(fw[6'(mf)], mb);
            end
        end
    end

    // ---------------- monitor / decoder ----------------
    bit          dec_on = 0;
    int          base = 0;
    int          j;
    logic [S-1:0] rx_cur = '0;
    logic [S-1:0] rx [0:15][0:1];
    int          first_act = -1, first_rise = -1, lr_r0 = -1, lr_r1 = -1;
    int          un_cnt = 0, ov_cnt = 0;
    logic        prev_lr = 1'b0;

    always @(negedge clk) begin
        if (mdl_en) begin
            checks++;
            if ({active, bclk, lrclk, sdata, under, over} !== {e_act, e_bclk, e_lr, e_sd, e_un, e_ov}) begin
                failures++;
                $display("FAIL cycle %0d act/bclk/lr/sd/un/ov: got %b required %b", cyc,
                         {active, bclk, lrclk, sdata, under, over}, {e_act, e_bclk, e_lr, e_sd, e_un, e_ov});
            end
        end
        if (under === 1'b1) un_cnt++;
        if (over === 1'b1)  ov_cnt++;
        if (dec_on) begin
            j = cyc - base;
            if (j >= 0 && j % D == 0) begin
                rx_cur = {rx_cur[S-2:0], sdata};
                if ((j % SLOT_CYC) / D == S - 1) rx[4'(j / FRAME)][1'((j / SLOT_CYC) % 2)] = rx_cur;
            end
            if (active === 1'b1 && first_act < 0) first_act = cyc;
            if (bclk === 1'b1 && first_rise < 0)  first_rise = cyc;
            if (lrclk === 1'b1 && prev_lr === 1'b0) begin
                if (lr_r0 < 0) lr_r0 = cyc;
                else if (lr_r1 < 0) lr_r1 = cyc;
            end
            prev_lr = lrclk;
        end
    end

    // ---------------- stimulus ----------------
    stim_t stim [0:6];
    frm_t  frames [0:8];

    initial begin
        // Strobe offsets are relative to the first RUN cycle (frame 0 load).
        stim[0] = '{-1,   16'hA5C3};
        stim[1] = '{999,  16'h8000};
        stim[2] = '{1999, 16'h7FFF};
        stim[3] = '{2999, 16'h8000};
        stim[4] = '{5500, 16'h1111};
        stim[5] = '{5510, 16'h2222};
        stim[6] = '{7000, 16'h0F0F};
        frames[0] = '{0, 16'hA5C3};
        frames[1] = '{1, 16'h8000};
        frames[2] = '{2, 16'h7FFF};
        frames[3] = '{3, 16'h8000};
        frames[4] = '{4, 16'h8000};
        frames[5] = '{5, 16'h8000};
        frames[6] = '{6, 16'h2222};
        frames[7] = '{7, 16'h0F0F};
        frames[8] = '{8, 16'h0000};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 32'({active, bclk, lrclk, sdata, under, over}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Directed scenario: steady, underrun, overrun, coincident, mute, mid-slot reset.
        base = cyc + 2;
        un_cnt = 0; ov_cnt = 0;
        dec_on = 1;
        for (int o = -1; o <= 9237; o++) begin
            valid  = 1'b0;
            sample = '0;
            foreach (stim[i]) if (stim[i].off == o) begin valid = 1'b1; sample = stim[i].smp; end
            mute = (o >= 7990 && o <= 8010);
            rst  = (o == 9237);
            @(negedge clk);
        end
        #1;
        chk("rst_mid_outputs", 32'({active, bclk, lrclk, sdata, under, over}), 32'd0);
        dec_on = 0;
        rst = 1'b0;
        chk("active_latency", first_act, base - 1);
        chk("first_bclk_rise", first_rise, base + D / 2);
        chk("lrclk_period", lr_r1 - lr_r0, FRAME);
        chk("underrun_pulses", un_cnt, 3);
        chk("overrun_pulses", ov_cnt, 1);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("frame%0d_L", frames[i].f), 32'(rx[4'(frames[i].f)][0]), 32'(exp_slot(frames[i].w)));
            chk($sformatf("frame%0d_R", frames[i].f), 32'(rx[4'(frames[i].f)][1]), 32'(exp_slot(frames[i].w)));
        end

        // Random strobes, mute toggles and occasional resets.
        for (int c = 0; c < 8000; c++) begin
            valid  = ($urandom_range(0, 249) == 0);
            sample = 16'($urandom);
            if ($urandom_range(0, 1499) == 0) mute = ~mute;
            rst    = ($urandom_range(0, 2999) == 0);
            @(negedge clk);
        end

        // Periodic strobes at the frame rate with random samples.
        rst = 1'b1; valid = 1'b0; mute = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        un_cnt = 0; ov_cnt = 0;
        for (int c = 0; c < 6 * FRAME; c++) begin
            valid  = (c % FRAME == 0);
            sample = 16'($urandom);
            @(negedge clk);
        end
        valid = 1'b0;
        #1;
        chk("steady_underrun", un_cnt, 0);
        chk("steady_overrun", ov_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio sink for the 48 kHz sample stream produced by the waveform generators; it is the consumer/transmit end of the sample + one-cycle-pulse interface.
- Latches each 16-bit signed sample on its strobe and serialises it as stereo I2S (mono duplicated to L and R) toward the external DAC.
- Runs entirely in the 48 MHz domain. BCLK = 2.4 MHz, LRCLK = 48 kHz, with 2 x 25-bit slots per 1000-cycle frame.

Parameters:
- BCLK_DIV, 20: i_clk48 cycles per BCLK period; must be even.
- SLOT_BITS, 25: BCLK periods per channel slot; must be >= 17.
- SAMPLE_W, 16: sample width.

Ports:
- i_clk48 in 1: 48 MHz system clock.
- i_rst48 in 1: synchronous, active-high reset.
- i_sample in SAMPLE_W: two's-complement sample; valid only while i_valid is high.
- i_valid in 1: one-cycle sample strobe (driven by the generator's o_pulse).
- i_mute in 1: when high, words loaded at frame start are forced to 0.
- o_bclk out 1: I2S bit clock.
- o_lrclk out 1: word select; 0 = left, 1 = right.
- o_sdata out 1: serial data, changes only on BCLK falling edges.
- o_active out 1: high while in RUN.
- o_underrun out 1: one-cycle pulse when a frame starts with no new sample.
- o_overrun out 1: one-cycle pulse when a pending sample is overwritten before it is loaded.

Behaviour:
- Reset: state IDLE, all counters 0, hold/shift registers 0, pending 0. All outputs 0.
- Sample capture: on i_valid, hold <= i_sample. If pending was already 1 and this is not a load cycle, o_overrun pulses next cycle; the newer sample wins.
- IDLE: o_bclk, o_lrclk and o_sdata are held at 0. On the first i_valid, capture the sample and go to RUN next cycle with bclk_cnt = 0, bit_cnt = 0, ch = 0 (left).
- RUN counters:
  - bclk_cnt runs 0..BCLK_DIV-1. bit_cnt advances when bclk_cnt wraps.
  - ch toggles when bit_cnt wraps from SLOT_BITS-1 to 0.
  - Frame start = bclk_cnt == 0 && bit_cnt == 0 && ch == 0.
- o_bclk = 0 for bclk_cnt < BCLK_DIV/2, else 1. This is registered, so it toggles one cycle after the compare.
- o_lrclk = ch, registered, updated in the same cycle as o_bclk falls.
- Frame-start load:
  - word <= i_mute ? 0 : (i_valid ? i_sample : hold). A simultaneous strobe bypasses the hold register.
  - pending clears, unless the strobe arrives in the same cycle.
  - If neither pending nor i_valid is set, word repeats the previous value and o_underrun pulses.
  - The same word is used for both the left and right slots.
- Bit mapping (I2S), bit slot b = bit_cnt:
  - o_sdata = word[SAMPLE_W-b] for 1 <= b <= SAMPLE_W.
  - o_sdata = 0 for b = 0 and for b > SAMPLE_W.
  - The MSB therefore lags the LRCLK edge by one BCLK.
- Latency: i_valid in IDLE at cycle t gives RUN at t+1, first o_bclk rise at t+2+BCLK_DIV/2, and the MSB on o_sdata from t+2+BCLK_DIV.
- Steady state: frame period = 2*SLOT_BITS*BCLK_DIV = 1000 cycles, equal to the strobe period. Each strobe therefore precedes its load by a fixed offset; no underrun or overrun occurs.
- Asserting i_rst48 mid-frame returns to IDLE immediately on the next edge, and all outputs drop to 0.
- i_valid never returns RUN to IDLE. Only reset leaves RUN.

Optional Feature:
- Macro I2S_TX_LEFT_JUSTIFIED_EN.
- Defined: left-justified format. o_sdata = word[SAMPLE_W-1-b] for 0 <= b < SAMPLE_W, else 0; the MSB coincides with the LRCLK edge.
- Undefined: standard I2S with the one-BCLK delay described above.
- Timing of o_bclk and o_lrclk is identical in both modes.

Decomposition:
- audio_pkg holds:
  - typedef sample_t (logic signed [15:0]).
  - localparams FS_HZ = 48000 and CLK_HZ = 48000000.
  - enum i2s_state_t {IDLE, RUN}.
- One natural sub-module, i2s_bitclk: bclk_cnt/bit_cnt/ch counters plus o_bclk/o_lrclk registers. It outputs a fall strobe, a frame_start strobe and bit_cnt. The top level owns capture, load and the data mux.

Test Plan:
- Reset then a single i_valid with 16'hA5C3 -> o_active high at t+1, first o_bclk rise at t+12. L slot shows 1010_0101_1100_0011 on bits 1..16, bits 0 and 17..24 are 0, and the R slot repeats it. o_lrclk period = 1000 cycles.
- Strobes every 1000 cycles with 16'h8000, then 16'h7FFF -> consecutive frames carry each value exactly once; o_underrun and o_overrun stay 0.
- Stop strobes after one sample -> o_underrun pulses once per frame and the last word (16'h8000) repeats.
- Two strobes 10 cycles apart (16'h1111, then 16'h2222) before a load -> one o_overrun pulse, and the frame transmits 16'h2222.
- Strobe coincident with the frame-start cycle carrying 16'h0F0F -> that frame transmits 16'h0F0F with no underrun. Then i_mute=1 -> the next frame is all zeros. Then i_rst48 mid-slot -> all outputs are 0 the next cycle and the block is back in IDLE.
- Build with I2S_TX_LEFT_JUSTIFIED_EN and sample 16'hC001 -> MSB 1 in bit slot 0 coincident with the LRCLK edge, LSB in slot 15, zeros in slots 16..24.
